// File: rtl/tilegen_layer_mixer.sv
// Multi-layer tile pixel mixer: skewed daisy-chain priority resolve with per-layer enable,
// priority override, background colour and VSYNC-committed shadow registers.
module tilegen_layer_mixer #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned PR_W       = 3,
  parameter int unsigned CL_W       = 8,
  parameter int unsigned DT_W       = 3
) (
  input  logic                       CLK_6M,
  input  logic                       RST_N,
  input  logic                       VSYNC,
  input  logic                       HBLANK,
  input  logic                       VBLANK,
  input  logic [NUM_LAYERS*PR_W-1:0] LPR,
  input  logic [NUM_LAYERS*CL_W-1:0] LCL,
  input  logic [NUM_LAYERS*DT_W-1:0] LDT,
  input  logic [3:0]                 CA,
  input  logic                       WE,
  input  logic [7:0]                 CD,
  output logic [PR_W-1:0]            PRO,
  output logic [CL_W-1:0]            CLO,
  output logic [DT_W-1:0]            DTO,
  output logic                       BLANK_O
);

  logic                  vsync_q;
  logic                  commit;
  logic [NUM_LAYERS-1:0] en_sh, en_q;
  logic [CL_W-1:0]       bg_sh, bg_q;
  logic [NUM_LAYERS-1:0] ov_en_sh, ov_en_q;
  logic [PR_W-1:0]       ov_pr_sh [NUM_LAYERS];
  logic [PR_W-1:0]       ov_pr_q  [NUM_LAYERS];

  // Commit copies the pre-write shadow when a write lands in the same cycle.
  assign commit = VSYNC & ~vsync_q;

  always_ff @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) begin
      vsync_q  <= 1'b0;
      en_sh    <= '1;
      en_q     <= '1;
      bg_sh    <= '0;
      bg_q     <= '0;
      ov_en_sh <= '0;
      ov_en_q  <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        ov_pr_sh[i] <= '0;
        ov_pr_q[i]  <= '0;
      end
    end else begin
      vsync_q <= VSYNC;
      if (commit) begin
        en_q    <= en_sh;
        bg_q    <= bg_sh;
        ov_en_q <= ov_en_sh;
        ov_pr_q <= ov_pr_sh;
      end
      if (WE) begin
        if (CA == 4'd0) en_sh <= CD[NUM_LAYERS-1:0];
        if (CA == 4'd1) bg_sh <= CL_W'(CD);
        for (int i = 0; i < NUM_LAYERS; i++) begin
          if (CA == 4'(i + 2)) begin
            ov_en_sh[i] <= CD[7];
            ov_pr_sh[i] <= CD[PR_W-1:0];
          end
        end
      end
    end
  end

  logic [PR_W-1:0] lay_pr [NUM_LAYERS];
  logic [CL_W-1:0] lay_cl [NUM_LAYERS];
  logic [DT_W-1:0] lay_dt [NUM_LAYERS];

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_skew
    if (g == 0) begin : g_direct
      assign lay_pr[g] = LPR[g*PR_W +: PR_W];
      assign lay_cl[g] = LCL[g*CL_W +: CL_W];
      assign lay_dt[g] = LDT[g*DT_W +: DT_W];
    end else begin : g_delay
      logic [PR_W-1:0] pr_sr [g];
      logic [CL_W-1:0] cl_sr [g];
      logic [DT_W-1:0] dt_sr [g];

      always_ff @(posedge CLK_6M or negedge RST_N) begin
        if (!RST_N) begin
          for (int d = 0; d < g; d++) begin
            pr_sr[d] <= '0;
            cl_sr[d] <= '0;
            dt_sr[d] <= '1;
          end
        end else begin
          pr_sr[0] <= LPR[g*PR_W +: PR_W];
          cl_sr[0] <= LCL[g*CL_W +: CL_W];
          dt_sr[0] <= LDT[g*DT_W +: DT_W];
          for (int d = 1; d < g; d++) begin
            pr_sr[d] <= pr_sr[d-1];
            cl_sr[d] <= cl_sr[d-1];
            dt_sr[d] <= dt_sr[d-1];
          end
        end
      end

      assign lay_pr[g] = pr_sr[g-1];
      assign lay_cl[g] = cl_sr[g-1];
      assign lay_dt[g] = dt_sr[g-1];
    end
  end

  logic [PR_W-1:0] stg_pr_q [NUM_LAYERS];
  logic [PR_W-1:0] stg_pr_d [NUM_LAYERS];
  logic [CL_W-1:0] stg_cl_q [NUM_LAYERS];
  logic [CL_W-1:0] stg_cl_d [NUM_LAYERS];
  logic [DT_W-1:0] stg_dt_q [NUM_LAYERS];
  logic [DT_W-1:0] stg_dt_d [NUM_LAYERS];
  logic            stg_bl_q [NUM_LAYERS];
  logic            stg_bl_d [NUM_LAYERS];
  logic [PR_W-1:0] car_pr   [NUM_LAYERS+1];
  logic [CL_W-1:0] car_cl   [NUM_LAYERS+1];
  logic [DT_W-1:0] car_dt   [NUM_LAYERS+1];
  logic            car_bl   [NUM_LAYERS+1];

  always_comb begin
    logic [PR_W-1:0] eff_pr;
    eff_pr    = '0;
    car_pr[0] = '0;
    car_cl[0] = bg_q;
    car_dt[0] = '1;
    car_bl[0] = HBLANK | VBLANK;
    for (int k = 1; k <= NUM_LAYERS; k++) begin
      car_pr[k] = stg_pr_q[k-1];
      car_cl[k] = stg_cl_q[k-1];
      car_dt[k] = stg_dt_q[k-1];
      car_bl[k] = stg_bl_q[k-1];
    end
    for (int i = 0; i < NUM_LAYERS; i++) begin
      eff_pr      = ov_en_q[i] ? ov_pr_q[i] : lay_pr[i];
      stg_pr_d[i] = car_pr[i];
      stg_cl_d[i] = car_cl[i];
      stg_dt_d[i] = car_dt[i];
      stg_bl_d[i] = car_bl[i];
      // >= lets the higher-index layer win ties.
      if (en_q[i] && (lay_dt[i] != '1) && (eff_pr >= car_pr[i])) begin
        stg_pr_d[i] = eff_pr;
        stg_cl_d[i] = lay_cl[i];
        stg_dt_d[i] = lay_dt[i];
      end
    end
  end

  always_ff @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        stg_pr_q[i] <= '0;
        stg_cl_q[i] <= '0;
        stg_dt_q[i] <= '1;
        stg_bl_q[i] <= 1'b1;
      end
      PRO     <= '0;
      CLO     <= '0;
      DTO     <= '1;
      BLANK_O <= 1'b1;
    end else begin
      stg_pr_q <= stg_pr_d;
      stg_cl_q <= stg_cl_d;
      stg_dt_q <= stg_dt_d;
      stg_bl_q <= stg_bl_d;
      BLANK_O  <= car_bl[NUM_LAYERS];
      if (car_bl[NUM_LAYERS]) begin
        PRO <= '0;
        CLO <= bg_q;
        DTO <= '1;
      end else begin
        PRO <= car_pr[NUM_LAYERS];
        CLO <= car_cl[NUM_LAYERS];
        DTO <= car_dt[NUM_LAYERS];
      end
    end
  end

endmodule

// File: tb/tb_tilegen_layer_mixer.sv
// Bench for tilegen_layer_mixer: directed scenarios plus random traffic against a dot-level
// reference model that resolves each dot from the priority rules and tracks register commits.
module tb_tilegen_layer_mixer;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0, hblank = 1'b0, vblank = 1'b0, we = 1'b0;
  logic [3:0] ca = '0;
  logic [7:0] cd = '0;
  logic [2:0] lpr [N];
  logic [7:0] lcl [N];
  logic [2:0] ldt [N];
  logic [N*3-1:0] lpr_v, ldt_v;
  logic [N*8-1:0] lcl_v;
  logic [2:0] pro, dto;
  logic [7:0] clo;
  logic       blank_o;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      lpr_v[i*3 +: 3] = lpr[i];
      lcl_v[i*8 +: 8] = lcl[i];
      ldt_v[i*3 +: 3] = ldt[i];
    end
  end

  tilegen_layer_mixer #(.NUM_LAYERS(N), .PR_W(3), .CL_W(8), .DT_W(3)) dut (
    .CLK_6M(clk), .RST_N(rst_n), .VSYNC(vsync), .HBLANK(hblank), .VBLANK(vblank),
    .LPR(lpr_v), .LCL(lcl_v), .LDT(ldt_v), .CA(ca), .WE(we), .CD(cd),
    .PRO(pro), .CLO(clo), .DTO(dto), .BLANK_O(blank_o)
  );

  always #5 clk = ~clk;

  // Reference register state.
  logic [N-1:0] m_en_sh, m_en;
  logic [7:0]   m_bg_sh, m_bg;
  logic         m_oven_sh [N];
  logic         m_oven    [N];
  logic [2:0]   m_ovpr_sh [N];
  logic [2:0]   m_ovpr    [N];
  logic         m_vs_prev;

  typedef struct packed {
    logic        skip;
    logic [14:0] tup;
  } exp_t;
  exp_t exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] ref_dot();
    logic [2:0] pr = 3'd0;
    logic [7:0] cl = m_bg;
    logic [2:0] dt = 3'd7;
    logic [2:0] p;
    if (hblank || vblank) return {3'd0, m_bg, 3'd7, 1'b1};
    for (int i = 0; i < N; i++) begin
      p = m_oven[i] ? m_ovpr[i] : lpr[i];
      if (m_en[i] && ldt[i] != 3'd7 && p >= pr) begin
        pr = p;
        cl = lcl[i];
        dt = ldt[i];
      end
    end
    return {pr, cl, dt, 1'b0};
  endfunction

  task automatic m_reset();
    m_en_sh = '1; m_en = '1; m_bg_sh = '0; m_bg = '0; m_vs_prev = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_oven_sh[i] = 1'b0; m_oven[i] = 1'b0; m_ovpr_sh[i] = '0; m_ovpr[i] = '0;
    end
    exp_q.delete();
  endtask

  // Called at a negedge with inputs set; advances one clock and returns at the next negedge.
  task automatic step();
    exp_t e;
    e.skip = 1'b0;
    e.tup  = ref_dot();
    exp_q.push_back(e);
    if (vsync && !m_vs_prev) begin
      // Dots still in flight straddle the commit; their result is not pinned down.
      for (int j = exp_q.size() - N; j < exp_q.size(); j++)
        if (j >= 0) exp_q[j].skip = 1'b1;
      m_en = m_en_sh; m_bg = m_bg_sh; m_oven = m_oven_sh; m_ovpr = m_ovpr_sh;
    end
    m_vs_prev = vsync;
    if (we) begin
      if (ca == 4'd0) m_en_sh = cd[N-1:0];
      else if (ca == 4'd1) m_bg_sh = cd;
      else if (int'(ca) < 2 + N) begin
        m_oven_sh[ca-2] = cd[7];
        m_ovpr_sh[ca-2] = cd[2:0];
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == N + 1) begin
      e = exp_q.pop_front();
      if (!e.skip) check_eq("dot", 32'({pro, clo, dto, blank_o}), 32'(e.tup));
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      lpr[i] = 3'($urandom_range(0, 7));
      lcl[i] = 8'($urandom_range(0, 255));
      ldt[i] = ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
    end
    hblank = ($urandom_range(0, 9) == 0);
    vblank = ($urandom_range(0, 19) == 0);
    vsync  = ($urandom_range(0, 29) == 0);
    we     = ($urandom_range(0, 3) == 0);
    ca     = 4'($urandom_range(0, 15));
    cd     = 8'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0] bl_seen;
    lpr = '{default: 3'd0};
    lcl = '{default: 8'd0};
    ldt = '{default: 3'd7};
    m_reset();

    repeat (6) begin
      @(negedge clk);
      rand_inputs();
      #1;
      check_eq("rst_hold", 32'({pro, clo, dto, blank_o}), 32'({3'd0, 8'd0, 3'd7, 1'b1}));
    end

    @(negedge clk);
    ldt = '{default: 3'd7};
    hblank = 0; vblank = 0; vsync = 0; we = 0;
    rst_n = 1'b1;
    m_reset();
    run(5);
    check_eq("rst_release", 32'({clo, dto, blank_o}), 32'({8'd0, 3'd7, 1'b0}));

    lpr = '{3'd1, 3'd3, 3'd3, 3'd2};
    lcl = '{8'd10, 8'd20, 8'd30, 8'd40};
    ldt = '{3'd0, 3'd1, 3'd2, 3'd3};
    run(5);
    check_eq("tie", 32'({pro, clo, dto}), 32'({3'd3, 8'd30, 3'd2}));
    ldt[2] = 3'd7;
    run(5);
    check_eq("tie_transparent", 32'({pro, clo, dto}), 32'({3'd3, 8'd20, 3'd1}));

    ldt[2] = 3'd2;
    we = 1; ca = 4'd0; cd = 8'h0D;
    step();
    we = 0;
    run(5);
    check_eq("en_shadow", 32'(clo), 32'd30);
    vsync = 1;
    step();
    vsync = 0;
    run(5);
    check_eq("en_commit", 32'(clo), 32'd30);
    ldt[2] = 3'd7;
    run(5);
    check_eq("en_mask", 32'({pro, clo}), 32'({3'd2, 8'd40}));

    we = 1; ca = 4'd1; cd = 8'h55; vsync = 1;
    step();
    we = 0; vsync = 0;
    ldt = '{default: 3'd7};
    run(5);
    check_eq("bg_hold", 32'(clo), 32'd0);
    run(20);
    check_eq("bg_hold_late", 32'(clo), 32'd0);
    vsync = 1;
    step();
    vsync = 0;
    run(5);
    check_eq("bg_commit", 32'({pro, clo, dto}), 32'({3'd0, 8'h55, 3'd7}));

    ldt = '{3'd0, 3'd1, 3'd2, 3'd3};
    we = 1; ca = 4'd2; cd = 8'h87;
    step();
    we = 0; vsync = 1;
    step();
    vsync = 0;
    run(5);
    check_eq("ovr_on", 32'({pro, clo, dto}), 32'({3'd7, 8'd10, 3'd0}));
    we = 1; ca = 4'd2; cd = 8'h07;
    step();
    we = 0; vsync = 1;
    step();
    vsync = 0;
    run(5);
    check_eq("ovr_off", 32'({pro, clo, dto}), 32'({3'd3, 8'd30, 3'd2}));

    hblank = 1;
    run(3);
    hblank = 0;
    bl_seen = '0;
    for (int j = 0; j < 10; j++) begin
      step();
      bl_seen[j] = blank_o;
    end
    check_eq("blank_window", 32'(bl_seen), 32'(10'b00_0000_1110));

    run(3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst", 32'({pro, clo, dto, blank_o}), 32'({3'd0, 8'd0, 3'd7, 1'b1}));
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    run(4);
    check_eq("rst_fill", 32'(blank_o), 32'd1);
    step();
    check_eq("rst_first", 32'({pro, clo, dto, blank_o}), 32'({3'd3, 8'd30, 3'd2, 1'b0}));

    repeat (3000) begin
      rand_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
